mm_uart_ctrl: RTL and testbench

- Parametrised, single-clock memory-mapped UART; successor to the TX-only peripheral.
- Adds a programmable baud divisor, a full RX path with mid-bit sampling, TX and RX FIFOs of configurable depth, a status/control register set, and an interrupt output.
- Sits on the CPU data bus next to the other MMIO devices.

---
 rtl/mm_uart_pkg.sv | 26 ++
 rtl/mm_uart_ctrl_fifo.sv | 56 +++++
 rtl/mm_uart_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mm_uart_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_uart_pkg.sv
// Shared definitions for the memory-mapped UART: register map, STATUS/CTRL
// bit positions and the TX/RX state encodings.
package mm_uart_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_DIV    = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_EMPTY    = 1;
  localparam int ST_RX_NONEMPTY = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_FRAME_ERR   = 5;
  localparam int ST_TX_BUSY     = 6;
  localparam int ST_TX_DROP     = 7;

  localparam int CTRL_RX_IRQ  = 0;
  localparam int CTRL_TXE_IRQ = 1;
  localparam int CTRL_ERR_IRQ = 2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mm_uart_ctrl_fifo.sv
// Synchronous FIFO with a show-ahead head (dout is the oldest entry).
// Handshake: push and pop are single-cycle requests. A pop is accepted only
// when not empty; a push is accepted when not full, or when full and a pop
// retires in the same cycle. Rejected requests have no effect.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally (power-of-two depth); count separates full/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mm_uart_ctrl.sv
// Memory-mapped UART: divisor-programmable TX/RX with FIFOs, sticky error
// flags and a level interrupt. Bus reads are registered into data_r.
module mm_uart_ctrl
  import mm_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 16,
  parameter int          DATA_BITS   = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        en_r,
  input  logic        en_w,
  input  logic [15:0] data_w,
  output logic [15:0] data_r,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic [15:0] div_reg, status_word, rd_val;
  logic [2:0]  ctrl_reg;
  logic        rx_overrun, frame_err, tx_drop;

  logic                 tx_push, tx_pop, tx_full, tx_empty;
  logic                 rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_BITS-1:0] tx_dout, rx_dout;
  logic [CW-1:0]        tx_count, rx_count;
  logic                 unused_counts;

  // TX datapath/FSM registers and next values
  tx_state_t            tx_state, tx_state_d;
  logic [15:0]          tx_cnt, tx_cnt_d, tx_div, tx_div_d;
  logic [BW-1:0]        tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_line_d, tx_busy;

  // RX datapath/FSM registers and next values
  rx_state_t            rx_state, rx_state_d;
  logic [15:0]          rx_cnt, rx_cnt_d, rx_div, rx_div_d, rx_half;
  logic [16:0]          div_p1;
  logic [BW-1:0]        rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_s1, rx_s2, rx_prev, rx_good, rx_ferr;

  logic wr_data, drop_evt, ovr_evt;

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .din(data_w[DATA_BITS-1:0]),
    .pop(tx_pop), .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .din(rx_shift_d),
    .pop(rx_pop), .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Occupancy counts are not needed at this level; full/empty suffice.
  assign unused_counts = ^{tx_count, rx_count};

  assign tx_busy  = (tx_state != TX_IDLE);
  assign wr_data  = en_w && (addr == ADDR_DATA);
  assign tx_push  = wr_data && !tx_full;
  assign drop_evt = wr_data && tx_full;
  assign rx_pop   = en_r && (addr == ADDR_DATA) && !rx_empty;
  assign rx_push  = rx_good;
  assign ovr_evt  = rx_good && rx_full && !rx_pop;

  // STATUS word assembled from live FIFO/FSM state and sticky flags.
  always_comb begin
    status_word = '0;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_TX_EMPTY]    = tx_empty;
    status_word[ST_RX_NONEMPTY] = !rx_empty;
    status_word[ST_RX_FULL]     = rx_full;
    status_word[ST_RX_OVERRUN]  = rx_overrun;
    status_word[ST_FRAME_ERR]   = frame_err;
    status_word[ST_TX_BUSY]     = tx_busy;
    status_word[ST_TX_DROP]     = tx_drop;
  end

  // Read mux; sees pre-write register values when read and write coincide.
  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_DATA:   if (!rx_empty) rd_val = {1'b1, {(15-DATA_BITS){1'b0}}, rx_dout};
      ADDR_STATUS: rd_val = status_word;
      ADDR_DIV:    rd_val = div_reg;
      ADDR_CTRL:   rd_val = {13'd0, ctrl_reg};
      default:     rd_val = '0;
    endcase
  end

  // Register file, sticky flags (a new event wins over a same-cycle clear) and irq.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r     <= '0;
      div_reg    <= DEFAULT_DIV;
      ctrl_reg   <= '0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (en_r) data_r <= rd_val;
      if (en_w && addr == ADDR_DIV)  div_reg  <= data_w;
      if (en_w && addr == ADDR_CTRL) ctrl_reg <= data_w[2:0];
      if (en_w && addr == ADDR_STATUS) begin
        if (data_w[ST_RX_OVERRUN]) rx_overrun <= 1'b0;
        if (data_w[ST_FRAME_ERR])  frame_err  <= 1'b0;
        if (data_w[ST_TX_DROP])    tx_drop    <= 1'b0;
      end
      if (ovr_evt)  rx_overrun <= 1'b1;
      if (rx_ferr)  frame_err  <= 1'b1;
      if (drop_evt) tx_drop    <= 1'b1;
      irq <= (ctrl_reg[CTRL_RX_IRQ]  && !rx_empty) ||
             (ctrl_reg[CTRL_TXE_IRQ] && tx_empty && !tx_busy) ||
             (ctrl_reg[CTRL_ERR_IRQ] && (rx_overrun || frame_err || tx_drop));
    end
  end

  // TX next-state: every non-idle state lasts tx_div+1 cycles; the divisor is
  // latched at frame start so a DIV write never disturbs a frame in flight.
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_div_d   = tx_div;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_pop     = 1'b0;
    if (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == '0)) begin
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_d = TX_START;
        tx_cnt_d   = div_reg;
        tx_div_d   = div_reg;
        tx_shift_d = tx_dout;
      end else begin
        tx_state_d = TX_IDLE;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt_d = tx_cnt - 16'd1;
    end else begin
      tx_cnt_d = tx_div;
      if (tx_state == TX_START) begin
        tx_state_d = TX_DATA;
        tx_bit_d   = '0;
      end else if (tx_bit == LAST_BIT) begin
        tx_state_d = TX_STOP;
      end else begin
        tx_bit_d   = tx_bit + BIT_ONE;
        tx_shift_d = tx_shift >> 1;
      end
    end
    case (tx_state_d)
      TX_START: tx_line_d = 1'b0;
      TX_DATA:  tx_line_d = tx_shift_d[0];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // TX state register; uart_tx is registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_div   <= tx_div_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      uart_tx  <= tx_line_d;
    end
  end

  // Two-flop synchroniser plus previous-sample flop for falling-edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign div_p1  = {1'b0, div_reg} + 17'd1;
  assign rx_half = div_p1[16:1];

  // RX next-state: start confirmed half a bit after the edge (immediately when
  // the half-bit is zero), then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt;
    rx_div_d   = rx_div;
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_good    = 1'b0;
    rx_ferr    = 1'b0;
    if (rx_state == RX_IDLE) begin
      if (rx_prev && !rx_s2) begin
        rx_div_d = div_reg;
        rx_bit_d = '0;
        if (rx_half == '0) begin
          rx_state_d = RX_DATA;
          rx_cnt_d   = div_reg;
        end else begin
          rx_state_d = RX_START;
          rx_cnt_d   = rx_half - 16'd1;
        end
      end
    end else if (rx_cnt != '0) begin
      rx_cnt_d = rx_cnt - 16'd1;
    end else begin
      rx_cnt_d = rx_div;
      case (rx_state)
        RX_START: rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        RX_DATA: begin
          rx_shift_d = {rx_s2, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_state_d = RX_STOP;
          else                    rx_bit_d   = rx_bit + BIT_ONE;
        end
        RX_STOP: begin
          rx_state_d = RX_IDLE;
          rx_good    = rx_s2;
          rx_ferr    = !rx_s2;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_div   <= rx_div_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_mm_uart_ctrl.sv
// Self-checking bench for mm_uart_ctrl: register table, TX waveform checks,
// RX frames against a queue-based reference, irq timing and reset abort.
module tb_mm_uart_ctrl;
  import mm_uart_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  addr;
  logic        en_r, en_w;
  logic [15:0] data_w, data_r;
  logic        uart_rx, uart_tx, irq;

  int checks = 0;
  int errors = 0;

  // Reference model: received bytes in order, sticky flags, bytes to transmit.
  logic [7:0] exp_q[$];
  logic [7:0] tx_q[$];
  bit m_ovr, m_fe, m_drop;

  typedef struct packed {
    logic [1:0]  a;
    logic        wr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [11];

  mm_uart_ctrl #(.FIFO_DEPTH(DEPTH), .DATA_BITS(8), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .rst(rst), .addr(addr), .en_r(en_r), .en_w(en_w),
    .data_w(data_w), .data_r(data_r), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Bus driver tasks; entered and left on a falling clock edge.
  task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
    addr = a; data_w = d; en_w = 1'b1;
    @(negedge clk);
    en_w = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [15:0] d);
    addr = a; en_r = 1'b1;
    @(negedge clk);
    en_r = 1'b0;
    d = data_r;
  endtask

  // STATUS expected while the transmitter is idle.
  function automatic logic [15:0] exp_status();
    return {8'h00, m_drop, 1'b0, m_fe, m_ovr, exp_q.size() == DEPTH, exp_q.size() != 0, 1'b1, 1'b0};
  endfunction

  task automatic model_rx(input logic [7:0] b, input bit stop);
    if (!stop) m_fe = 1'b1;
    else if (exp_q.size() == DEPTH) m_ovr = 1'b1;
    else exp_q.push_back(b);
  endtask

  // Drive one serial frame (LSB first) at the given divisor, then idle-high.
  task automatic send_rx(input logic [7:0] b, input bit stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = bits[i];
      repeat (div + 1) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (div + 4) @(negedge clk);
    model_rx(b, stop);
  endtask

  task automatic check_status(input string name);
    logic [15:0] rd;
    bus_read(ADDR_STATUS, rd);
    check(name, rd, exp_status());
  endtask

  // Read DATA once and compare with the head of the reference queue.
  task automatic read_data(input string name);
    logic [15:0] rd;
    logic [15:0] e;
    e = 16'h0000;
    if (exp_q.size() != 0) e = {8'h80, exp_q.pop_front()};
    bus_read(ADDR_DATA, rd);
    check(name, rd, e);
  endtask

  // Write all of tx_q and check the serial line cycle by cycle, plus the
  // tx-empty interrupt (CTRL=2) rising once the last stop bit has ended.
  task automatic tx_run(input int div);
    int n, total, per;
    bit seen;
    n = tx_q.size();
    per = 10 * (div + 1);
    total = n * per;
    seen = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) bus_write(ADDR_DATA, {8'h00, tx_q[i]});
      end
      begin
        for (int w = 0; w < 20; w++) begin
          if (uart_tx === 1'b0) begin
            seen = 1'b1;
            break;
          end
          @(negedge clk);
        end
        check("tx_start_seen", {15'd0, seen}, 16'h0001);
        if (seen) begin
          for (int k = 0; k < total; k++) begin
            int f, p;
            logic e;
            f = k / per;
            p = (k % per) / (div + 1);
            if (p == 0)      e = 1'b0;
            else if (p == 9) e = 1'b1;
            else             e = tx_q[f][p-1];
            check($sformatf("tx_line_k%0d", k), {14'd0, uart_tx, irq}, {14'd0, e, 1'b0});
            @(negedge clk);
          end
          check("tx_end_irq_low", {14'd0, uart_tx, irq}, 16'h0002);
          @(negedge clk);
          check("tx_end_irq_high", {14'd0, uart_tx, irq}, 16'h0003);
        end
      end
    join
    tx_q.delete();
  endtask

  initial begin
    logic [15:0] rd;
    int div, rise_k;

    // Reset
    rst = 1'b1; en_r = 1'b0; en_w = 1'b0; addr = 2'd0; data_w = 16'h0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {15'd0, uart_tx}, 16'h0001);
    check("rst_data_r", data_r, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // Register table
    tbl[0]  = '{ADDR_STATUS, 1'b0, 16'h0000, 16'h0002};
    tbl[1]  = '{ADDR_DIV,    1'b0, 16'h0000, 16'd433};
    tbl[2]  = '{ADDR_CTRL,   1'b0, 16'h0000, 16'h0000};
    tbl[3]  = '{ADDR_DATA,   1'b0, 16'h0000, 16'h0000};
    tbl[4]  = '{ADDR_DIV,    1'b1, 16'd3,    16'h0000};
    tbl[5]  = '{ADDR_DIV,    1'b0, 16'h0000, 16'd3};
    tbl[6]  = '{ADDR_CTRL,   1'b1, 16'h0007, 16'h0000};
    tbl[7]  = '{ADDR_CTRL,   1'b0, 16'h0000, 16'h0007};
    tbl[8]  = '{ADDR_CTRL,   1'b1, 16'hFFF8, 16'h0000};
    tbl[9]  = '{ADDR_CTRL,   1'b0, 16'h0000, 16'h0000};
    tbl[10] = '{ADDR_STATUS, 1'b0, 16'h0000, 16'h0002};
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].wr) bus_write(tbl[i].a, tbl[i].wd);
      else begin
        bus_read(tbl[i].a, rd);
        check($sformatf("vec%0d", i), rd, tbl[i].exp);
      end
    end

    // TX: two back-to-back 0x55 frames at DIV=3
    bus_write(ADDR_CTRL, 16'h0002);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h55);
    tx_run(3);

    // TX: random divisors and byte counts
    for (int it = 0; it < 3; it++) begin
      div = $urandom_range(0, 3);
      bus_write(ADDR_DIV, 16'(div));
      repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom));
      tx_run(div);
    end
    bus_write(ADDR_CTRL, 16'h0000);
    bus_write(ADDR_DIV, 16'd3);

    // RX: single 0xA3 frame, then empty reads
    send_rx(8'hA3, 1'b1, 3);
    check_status("rx_status_after_a3");
    read_data("rx_data_a3");
    check_status("rx_status_drained");
    read_data("rx_data_empty");

    // RX: stop bit low -> frame error, W1C, then a 1-cycle glitch
    send_rx(8'h3C, 1'b0, 3);
    check_status("rx_frame_err");
    bus_write(ADDR_STATUS, 16'h0020);
    m_fe = 1'b0;
    check_status("rx_frame_err_cleared");
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (12) @(negedge clk);
    check_status("rx_glitch_no_frame");
    read_data("rx_glitch_data");

    // RX: overflow with DEPTH+1 frames
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'($urandom), 1'b1, 3);
    check_status("rx_overflow_status");
    check("rx_overflow_model", exp_status(), 16'h001E);
    for (int i = 0; i < DEPTH; i++) read_data($sformatf("rx_fifo_order%0d", i));
    bus_write(ADDR_STATUS, 16'h0010);
    m_ovr = 1'b0;
    check_status("rx_overrun_cleared");

    // RX: random divisors (including 0) and random stop bits
    for (int it = 0; it < 3; it++) begin
      div = (it == 0) ? 0 : $urandom_range(1, 5);
      bus_write(ADDR_DIV, 16'(div));
      repeat (6) send_rx(8'($urandom), $urandom_range(0, 4) != 0, div);
      check_status($sformatf("rx_rand_status%0d", it));
      while (exp_q.size() != 0) read_data($sformatf("rx_rand_data%0d", it));
      read_data($sformatf("rx_rand_empty%0d", it));
      bus_write(ADDR_STATUS, 16'h00B0);
      m_ovr = 1'b0; m_fe = 1'b0; m_drop = 1'b0;
      check_status($sformatf("rx_rand_cleared%0d", it));
    end

    // IRQ on receive: rises 2 (sync) + half bit + 9 bit periods + 2 cycles
    // after the start edge is driven; falls the cycle after the emptying read.
    div = 3;
    bus_write(ADDR_DIV, 16'(div));
    bus_write(ADDR_CTRL, 16'h0001);
    @(negedge clk);
    check("irq_idle_low", {15'd0, irq}, 16'h0000);
    rise_k = -1;
    fork
      send_rx(8'h5A, 1'b1, div);
      begin
        for (int k = 0; k < 100; k++) begin
          if (irq === 1'b1) begin
            rise_k = k;
            break;
          end
          @(negedge clk);
        end
      end
    join
    check("irq_rise_cycle", 16'(rise_k), 16'(2 + (div + 1) / 2 + 9 * (div + 1) + 2));
    read_data("irq_rx_data");
    check("irq_still_high", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    check("irq_fell", {15'd0, irq}, 16'h0000);
    bus_write(ADDR_CTRL, 16'h0000);

    // Fill TX past capacity (one byte leaves for the shifter), then reset mid-frame
    for (int i = 0; i < 20; i++) bus_write(ADDR_DATA, 16'h0000);
    bus_read(ADDR_STATUS, rd);
    check("tx_full_drop_status", rd, 16'h00C1);
    repeat (10) @(negedge clk);
    check("tx_mid_frame_low", {15'd0, uart_tx}, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame_tx", {15'd0, uart_tx}, 16'h0001);
    rst = 1'b0;
    m_drop = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
    exp_q.delete();
    check_status("rst_mid_frame_status");
    bus_read(ADDR_DIV, rd);
    check("rst_mid_frame_div", rd, 16'd433);
    repeat (5) @(negedge clk);
    check("rst_tx_stays_idle", {15'd0, uart_tx}, 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
